team_06_lcd_i2c: RTL

TEAM_06_LCD_I2C -- requirements
Module: team_06_lcd_i2c

---
 rtl/team_06_lcd_i2c.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/team_06_lcd_i2c.sv
`default_nettype none
// ============================================================================
// Module   : team_06_lcd_i2c
// Purpose  : I2C master that delivers one 4-bit LCD command to a PCF8574-style
//            backpack as START, address byte, byte with EN=1, byte with EN=0,
//            STOP, followed by a settle gap before the next command is taken.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active high
//   lcdOut     in   [5]=R/W, [4]=RS, [3:0]=DB7-4
//   trans      in   request to transmit lcdOut
//   sda_i      in   sampled SDA line
//   scl        out  I2C clock (push-pull)
//   sda_oe     out  1 = pull SDA low, 0 = release
//   i2cState   out  BEGINS=0, SEND=1, ACK=2, ENDS=3, OFF=4
//   ready      out  one-cycle pulse when the command has been delivered
//   commsError out  one-cycle pulse when a NACK aborted the transaction
// ============================================================================
module team_06_lcd_i2c #(
    parameter int unsigned CLK_DIV    = 25,
    parameter logic [6:0]  I2C_ADDR   = 7'h27,
    parameter int unsigned GAP_CYCLES = 2000,
    parameter logic        BACKLIGHT  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] lcdOut,
    input  logic       trans,
    input  logic       sda_i,
    output logic       scl,
    output logic       sda_oe,
    output logic [2:0] i2cState,
    output logic       ready,
    output logic       commsError
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] c_gap_max = GAP_W'(GAP_CYCLES - 1);

    // S_GAP is the post-STOP settle period; it is reported as ENDS.
    typedef enum logic [2:0] {
        S_BEGINS = 3'd0,
        S_SEND   = 3'd1,
        S_ACK    = 3'd2,
        S_ENDS   = 3'd3,
        S_OFF    = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;       // cycles within a phase
    logic [1:0]         phase_q, phase_d;   // quarter of the SCL period
    logic [2:0]         bit_q, bit_d;       // data bit index, 0 = MSB
    logic [1:0]         byte_q, byte_d;     // 0 = address, 1 = EN high, 2 = EN low
    logic [5:0]         cmd_q, cmd_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               nack_q, nack_d;     // sticky for the rest of the transaction
    logic               scl_q, scl_d;
    logic               sda_oe_q, sda_oe_d;
    logic [2:0]         i2cState_q, i2cState_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;

    logic               w_tick;
    logic               w_bit_end;
    logic [7:0]         w_byte;
    logic               w_bitval;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_OFF;
            cnt_q      <= '0;
            phase_q    <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            cmd_q      <= '0;
            gap_q      <= '0;
            nack_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            i2cState_q <= S_OFF;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            cmd_q      <= cmd_d;
            gap_q      <= gap_d;
            nack_q     <= nack_d;
            scl_q      <= scl_d;
            sda_oe_q   <= sda_oe_d;
            i2cState_q <= i2cState_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic. Bus outputs are computed from the *next* state/phase
    // so that the registered pins line up with the state registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        cmd_d     = cmd_q;
        gap_d     = gap_q;
        nack_d    = nack_q;
        w_tick    = (cnt_q == c_cnt_max);
        w_bit_end = w_tick && (phase_q == 2'd3);

        if (state_q inside {S_BEGINS, S_SEND, S_ACK, S_ENDS}) begin
            if (w_tick) begin
                cnt_d   = '0;
                phase_d = phase_q + 2'd1;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_OFF: begin
                // The ready cycle is excluded so a held trans cannot resend
                // the previous command before the host has advanced lcdOut.
                if (trans && !ready_q) begin
                    state_d = S_BEGINS;
                    cmd_d   = lcdOut;
                    byte_d  = 2'd0;
                    nack_d  = 1'b0;
                end
            end
            S_BEGINS: begin
                if (w_bit_end) state_d = S_SEND;
            end
            S_SEND: begin
                if (w_bit_end) begin
                    if (bit_q == 3'd7) state_d = S_ACK;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_ACK: begin
                if (w_tick && (phase_q == 2'd2)) nack_d = sda_i;
                if (w_bit_end) begin
                    if (nack_q || (byte_q == 2'd2)) begin
                        state_d = S_ENDS;
                    end else begin
                        state_d = S_SEND;
                        byte_d  = byte_q + 2'd1;
                    end
                end
            end
            S_ENDS: begin
                if (w_bit_end) state_d = nack_q ? S_OFF : S_GAP;
            end
            S_GAP: begin
                if (gap_q == c_gap_max) state_d = S_OFF;
                else                    gap_d   = gap_q + 1'b1;
            end
            default: state_d = S_OFF;
        endcase

        if (state_d != state_q) begin
            cnt_d   = '0;
            phase_d = '0;
            bit_d   = '0;
            gap_d   = '0;
        end

        case (byte_d)
            2'd0:    w_byte = {I2C_ADDR, 1'b0};
            2'd1:    w_byte = {cmd_d[3:0], BACKLIGHT, 1'b1, cmd_d[5], cmd_d[4]};
            default: w_byte = {cmd_d[3:0], BACKLIGHT, 1'b0, cmd_d[5], cmd_d[4]};
        endcase
        w_bitval = w_byte[3'd7 - bit_d];

        scl_d      = 1'b1;
        sda_oe_d   = 1'b0;
        i2cState_d = state_d;
        case (state_d)
            S_BEGINS: sda_oe_d = phase_d[1];
            S_SEND: begin
                scl_d    = phase_d[1];
                sda_oe_d = ~w_bitval;
            end
            S_ACK:    scl_d = phase_d[1];
            S_ENDS: begin
                scl_d    = (phase_d != 2'd0);
                sda_oe_d = (phase_d != 2'd3);
            end
            S_GAP:    i2cState_d = S_ENDS;
            default:  ;
        endcase

        ready_d = (state_q == S_GAP)  && (state_d == S_OFF);
        err_d   = (state_q == S_ENDS) && (state_d == S_OFF);
    end

    assign scl        = scl_q;
    assign sda_oe     = sda_oe_q;
    assign i2cState   = i2cState_q;
    assign ready      = ready_q;
    assign commsError = err_q;

endmodule
`default_nettype wire
